// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: operation modes
// and the elaboration-time geometry check.
package cla_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // True when the operand width splits evenly into lookahead groups.
  function automatic logic width_ok(input int unsigned width, input int unsigned grp);
    return (grp != 32'd0) && (width != 32'd0) && ((width % grp) == 32'd0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GRP-bit carry-lookahead group: sum bits, carry out and the
// carry into the group MSB (used for signed overflow on the top group).
module cla_group #(
  parameter int GRP = 4
) (
  input  logic [GRP-1:0] a,
  input  logic [GRP-1:0] b,
  input  logic           cin,
  output logic [GRP-1:0] sum,
  output logic           cout,
  output logic           c_msb
);

  logic [GRP-1:0] p_s;
  logic [GRP-1:0] g_s;
  logic [GRP:0]   c_s;

  // In-group propagate/generate and carry chain.
  always_comb begin
    p_s    = a ^ b;
    g_s    = a & b;
    c_s    = {(GRP+1){1'b0}};
    c_s[0] = cin;
    for (int i = 0; i < GRP; i++) begin
      c_s[i+1] = g_s[i] | (p_s[i] & c_s[i]);
    end
    sum   = p_s ^ c_s[GRP-1:0];
    cout  = c_s[GRP];
    c_msb = c_s[GRP-1];
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Adder/subtractor pipelined one lookahead group per stage; operands shift
// down as groups are consumed while completed sum groups accumulate.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GRP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP = WIDTH / GRP;

  if (!width_ok(WIDTH, GRP)) begin : g_width_check
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of GRP");
  end

  logic             advance_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             cin_eff_s;

  logic [GRP-1:0]   ga_s  [NGRP];
  logic [GRP-1:0]   gb_s  [NGRP];
  logic             gc_s  [NGRP];
  logic [GRP-1:0]   gs_s  [NGRP];
  logic             gco_s [NGRP];
  logic             gcm_s [NGRP];

  logic             vld_d [NGRP];
  logic             vld_q [NGRP];
  logic [WIDTH-1:0] a_d   [NGRP];
  logic [WIDTH-1:0] a_q   [NGRP];
  logic [WIDTH-1:0] b_d   [NGRP];
  logic [WIDTH-1:0] b_q   [NGRP];
  logic [WIDTH-1:0] sum_d [NGRP];
  logic [WIDTH-1:0] sum_q [NGRP];
  logic             c_d   [NGRP];
  logic             c_q   [NGRP];
  logic             ovf_d;
  logic             ovf_q;

  assign advance_s = !vld_q[NGRP-1] || out_ready;
  assign in_ready  = advance_s;
  assign out_valid = vld_q[NGRP-1];
  assign sum       = sum_q[NGRP-1];
  assign cout      = c_q[NGRP-1];
  assign ovf       = ovf_q;

  // Group operands: stage 0 from the ports, later stages from the low group
  // of the previous stage's shifted operands.
  always_comb begin
    b_eff_s   = (sub == MODE_SUB) ? ~b : b;
    cin_eff_s = (sub == MODE_SUB) ? 1'b1 : cin;
    ga_s[0]   = a[GRP-1:0];
    gb_s[0]   = b_eff_s[GRP-1:0];
    gc_s[0]   = cin_eff_s;
    for (int k = 1; k < NGRP; k++) begin
      ga_s[k] = a_q[k-1][GRP-1:0];
      gb_s[k] = b_q[k-1][GRP-1:0];
      gc_s[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    cla_group #(.GRP(GRP)) u_grp (
      .a     (ga_s[k]),
      .b     (gb_s[k]),
      .cin   (gc_s[k]),
      .sum   (gs_s[k]),
      .cout  (gco_s[k]),
      .c_msb (gcm_s[k])
    );
  end

  // Next stage contents; bubbles travel with their valid bit cleared.
  always_comb begin
    ovf_d            = gcm_s[NGRP-1] ^ gco_s[NGRP-1];
    vld_d[0]         = in_valid;
    a_d[0]           = a >> GRP;
    b_d[0]           = b_eff_s >> GRP;
    sum_d[0]         = {WIDTH{1'b0}};
    sum_d[0][GRP-1:0] = gs_s[0];
    c_d[0]           = gco_s[0];
    for (int k = 1; k < NGRP; k++) begin
      vld_d[k]                = vld_q[k-1];
      a_d[k]                  = a_q[k-1] >> GRP;
      b_d[k]                  = b_q[k-1] >> GRP;
      sum_d[k]                = sum_q[k-1];
      sum_d[k][k*GRP +: GRP]  = gs_s[k];
      c_d[k]                  = gco_s[k];
    end
  end

  // Whole pipeline shifts together on advance; reset flushes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NGRP; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= {WIDTH{1'b0}};
        b_q[k]   <= {WIDTH{1'b0}};
        sum_q[k] <= {WIDTH{1'b0}};
        c_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance_s) begin
      for (int k = 0; k < NGRP; k++) begin
        vld_q[k] <= vld_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
        c_q[k]   <= c_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; SHALL be a positive multiple of GRP.
REQ-002 Parameter GRP, default 4: bits per carry-lookahead group; NGRP = WIDTH/GRP pipeline stages.
REQ-003 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 in_valid  input  1: operand beat offered.
REQ-006 in_ready  output  1: beat accepted when in_valid && in_ready at a rising edge.
REQ-007 a  input  WIDTH: operand A.
REQ-008 b  input  WIDTH: operand B.
REQ-009 cin  input  1: carry-in; ignored when sub=1.
REQ-010 sub  input  1: 0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 out_valid  output  1: result beat present.
REQ-012 out_ready  input  1: result consumed when out_valid && out_ready at a rising edge.
REQ-013 sum  output  WIDTH: result.
REQ-014 cout  output  1: carry out of MSB (for sub: 1 = no borrow).
REQ-015 ovf  output  1: two's-complement signed overflow.

Function
REQ-016 Stage k (0..NGRP-1) SHALL compute group k's GRP sum bits with full in-group lookahead (p=a^b, g=a&b, c[i+1]=g[i]|p[i]&c[i]) from the carry registered by stage k-1 (stage 0 uses effective cin).
REQ-017 Unprocessed operand groups and completed sum groups SHALL be carried forward in skew registers so each beat's bits stay aligned.
REQ-018 Latency SHALL be exactly NGRP cycles from acceptance to out_valid with no stall.
REQ-019 Global advance = !out_valid || out_ready; all stage registers and per-stage valid bits SHALL shift only when advance=1.
REQ-020 in_ready SHALL equal advance (combinational from out_ready and out_valid).
REQ-021 A stage with valid=0 SHALL capture bubbles; throughput one beat per cycle when out_ready=1.
REQ-022 sum/cout/ovf SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 ovf SHALL equal carry into MSB XOR carry out of MSB for the final group.
REQ-024 sub captured per beat; mixed add/sub beats in flight SHALL each compute their own mode.
REQ-025 No beat SHALL be dropped, duplicated or reordered under any out_ready pattern.

Reset
REQ-026 While rst_n=0: all stage valid bits, out_valid, sum, cout, ovf and all data/carry registers SHALL be 0, asynchronously.
REQ-027 in_ready SHALL read 1 during and after reset (pipeline empty).
REQ-028 Beats in flight at reset assertion SHALL be discarded; none emerge after release.

Structure
REQ-029 Shared package cla_pkg SHALL hold mode constants (MODE_ADD=0, MODE_SUB=1) and an elaboration check function for WIDTH % GRP == 0.
REQ-030 One combinational sub-module cla_group (parameter GRP; inputs a, b, cin; outputs sum, cout, carry into MSB) SHALL be instantiated NGRP times.
REQ-031 Block SHALL contain no latches and no combinational path other than out_ready/out_valid -> in_ready.

Verification (WIDTH=16, GRP=4, latency 4)
REQ-032 a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
REQ-033 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1; a=0x1234, b=0x1111, cin=1 -> sum=0x2346.
REQ-034 a=0x0005, b=0x0007, sub=1 (cin=1 ignored) -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
REQ-035 Six back-to-back beats, out_ready low 3 cycles after first result -> in_ready low while stalled, sum held, all six results emerge in order with correct values.
REQ-036 rst_n low for one cycle with 2 beats in flight -> out_valid=0 immediately, in_ready=1, no stale results after release; next beat completes in 4 cycles.
REQ-037 Random add/sub beats with random out_ready, checked against reference model -> zero mismatches over 10000 beats.
